// File: rtl/urv_wb_stage_pkg.sv
// Shared definitions for the uRV writeback stage: widths, load funct3 codes,
// FSM states and the register-file write payload.
package urv_wb_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FUN_W  = 3;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned ECC_W  = 7;

  localparam logic [FUN_W-1:0] FUN_LB  = 3'b000;
  localparam logic [FUN_W-1:0] FUN_LH  = 3'b001;
  localparam logic [FUN_W-1:0] FUN_LW  = 3'b010;
  localparam logic [FUN_W-1:0] FUN_LBU = 3'b100;
  localparam logic [FUN_W-1:0] FUN_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic             store;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
  } wb_write_t;

endpackage

// File: rtl/urv_wb_stage_if.sv
// Execute/data-memory side and register-file side of the writeback stage.
interface urv_wb_stage_if;
  import urv_wb_stage_pkg::*;

  logic              x_valid_i;
  logic              x_ready_o;
  logic [REG_W-1:0]  x_rd_i;
  logic              x_rd_write_i;
  logic [XLEN-1:0]   x_rd_value_i;
  logic              x_load_i;
  logic [FUN_W-1:0]  x_fun_i;
  logic [ADDR_W-1:0] x_dm_addr_i;
  logic              dm_load_done_i;
  logic [XLEN-1:0]   dm_data_l_i;
  logic              w_load_pending_o;
  logic [REG_W-1:0]  rf_rd_o;
  logic [XLEN-1:0]   rf_rd_value_o;
  logic [ECC_W-1:0]  rf_rd_ecc_o;
  logic              rf_rd_store_o;
  logic              w_bypass_rd_write_o;
  logic [XLEN-1:0]   w_bypass_rd_value_o;

  modport slave (
    input  x_valid_i, x_rd_i, x_rd_write_i, x_rd_value_i, x_load_i, x_fun_i,
           x_dm_addr_i, dm_load_done_i, dm_data_l_i,
    output x_ready_o, w_load_pending_o, rf_rd_o, rf_rd_value_o, rf_rd_ecc_o,
           rf_rd_store_o, w_bypass_rd_write_o, w_bypass_rd_value_o
  );

  modport master (
    output x_valid_i, x_rd_i, x_rd_write_i, x_rd_value_i, x_load_i, x_fun_i,
           x_dm_addr_i, dm_load_done_i, dm_data_l_i,
    input  x_ready_o, w_load_pending_o, rf_rd_o, rf_rd_value_o, rf_rd_ecc_o,
           rf_rd_store_o, w_bypass_rd_write_o, w_bypass_rd_value_o
  );
endinterface

// File: rtl/urv_ecc.sv
// 7-bit SEC-DED code over a 32-bit word: Hamming(38,32) check bits plus overall parity.
module urv_ecc (
  input  logic [31:0] dat_i,
  output logic [6:0]  ecc_o
);

  // Data bit i occupies codeword position 3,5,6,7,9,... (powers of two are check bits).
  function automatic logic [31:0] parity_mask(input int k);
    logic [31:0] m;
    int unsigned pos;
    m   = '0;
    pos = 2;
    for (int i = 0; i < 32; i++) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) == 0) pos = pos + 1;
      m[i] = ((pos >> k) & 1) != 0;
    end
    return m;
  endfunction

  logic [5:0] hamming;

  for (genvar k = 0; k < 6; k++) begin : g_chk
    assign hamming[k] = ^(dat_i & parity_mask(k));
  end

  assign ecc_o = {^{dat_i, hamming}, hamming};

endmodule

// File: rtl/urv_wb_stage.sv
// uRV writeback stage: retires ALU results directly, waits for and aligns load data,
// and drives the register-file write port plus the W-stage bypass.
module urv_wb_stage
  import urv_wb_stage_pkg::*;
#(
  parameter int unsigned g_with_ecc = 0
) (
  input logic           clk_i,
  input logic           rst_n_i,
  urv_wb_stage_if.slave bus
);

  function automatic logic [XLEN-1:0] load_align(input logic [FUN_W-1:0]  fun,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic [XLEN-1:0]   data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{addr, 3'b000} +: 8];
    h = addr[1] ? data[31:16] : data[15:0];
    case (fun)
      FUN_LB:  return {{24{b[7]}}, b};
      FUN_LBU: return {24'b0, b};
      FUN_LH:  return {{16{h[15]}}, h};
      FUN_LHU: return {16'b0, h};
      default: return data;
    endcase
  endfunction

  wb_state_t         state, state_next;
  wb_write_t         wr_q, wr_next;
  logic              ready_q, ready_next;
  logic              pending_q, pending_next;
  logic [REG_W-1:0]  ld_rd, ld_rd_next;
  logic              ld_write, ld_write_next;
  logic [FUN_W-1:0]  ld_fun, ld_fun_next;
  logic [ADDR_W-1:0] ld_addr, ld_addr_next;
  logic [ECC_W-1:0]  ecc_q, ecc_next;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state, latched load context and the next register-file write.
  always_comb begin
    state_next    = state;
    wr_next       = wr_q;
    wr_next.store = 1'b0;
    ld_rd_next    = ld_rd;
    ld_write_next = ld_write;
    ld_fun_next   = ld_fun;
    ld_addr_next  = ld_addr;
    unique case (state)
      ST_IDLE: begin
        if (bus.x_valid_i && ready_q) begin
          if (bus.x_load_i) begin
            ld_rd_next    = bus.x_rd_i;
            ld_write_next = bus.x_rd_write_i;
            ld_fun_next   = bus.x_fun_i;
            ld_addr_next  = bus.x_dm_addr_i;
            state_next    = ST_LOAD_WAIT;
          end else begin
            wr_next.rd    = bus.x_rd_i;
            wr_next.value = bus.x_rd_value_i;
            wr_next.store = bus.x_rd_write_i && (bus.x_rd_i != '0);
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (bus.dm_load_done_i) begin
          wr_next.rd    = ld_rd;
          wr_next.value = load_align(ld_fun, ld_addr, bus.dm_data_l_i);
          wr_next.store = ld_write && (ld_rd != '0);
          state_next    = ST_IDLE;
        end
      end
    endcase
    ready_next   = (state_next == ST_IDLE);
    pending_next = (state_next == ST_LOAD_WAIT);
  end

  if (g_with_ecc != 0) begin : g_ecc
    urv_ecc u_ecc (.dat_i(wr_next.value), .ecc_o(ecc_next));
  end else begin : g_no_ecc
    assign ecc_next = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q      <= '0;
      ecc_q     <= '0;
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      ld_rd     <= '0;
      ld_write  <= 1'b0;
      ld_fun    <= '0;
      ld_addr   <= '0;
    end else begin
      wr_q      <= wr_next;
      ecc_q     <= ecc_next;
      ready_q   <= ready_next;
      pending_q <= pending_next;
      ld_rd     <= ld_rd_next;
      ld_write  <= ld_write_next;
      ld_fun    <= ld_fun_next;
      ld_addr   <= ld_addr_next;
    end
  end

  assign bus.x_ready_o           = ready_q;
  assign bus.w_load_pending_o    = pending_q;
  assign bus.rf_rd_o             = wr_q.rd;
  assign bus.rf_rd_value_o       = wr_q.value;
  assign bus.rf_rd_ecc_o         = ecc_q;
  assign bus.rf_rd_store_o       = wr_q.store;
  assign bus.w_bypass_rd_write_o = wr_q.store;
  assign bus.w_bypass_rd_value_o = wr_q.value;

endmodule

// File: tb/tb_urv_wb_stage.sv
// Scoreboard bench for urv_wb_stage: one ECC-enabled and one ECC-less instance share stimulus.
module tb_urv_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0;
  logic [4:0]  x_rd = '0;
  logic        x_rd_write = 1'b0;
  logic [31:0] x_rd_value = '0;
  logic        x_load = 1'b0;
  logic [2:0]  x_fun = '0;
  logic [1:0]  x_addr = '0;
  logic        dm_done = 1'b0;
  logic [31:0] dm_data = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  urv_wb_stage_if ifa ();
  urv_wb_stage_if ifb ();

  assign ifa.x_valid_i = x_valid;       assign ifb.x_valid_i = x_valid;
  assign ifa.x_rd_i = x_rd;             assign ifb.x_rd_i = x_rd;
  assign ifa.x_rd_write_i = x_rd_write; assign ifb.x_rd_write_i = x_rd_write;
  assign ifa.x_rd_value_i = x_rd_value; assign ifb.x_rd_value_i = x_rd_value;
  assign ifa.x_load_i = x_load;         assign ifb.x_load_i = x_load;
  assign ifa.x_fun_i = x_fun;           assign ifb.x_fun_i = x_fun;
  assign ifa.x_dm_addr_i = x_addr;      assign ifb.x_dm_addr_i = x_addr;
  assign ifa.dm_load_done_i = dm_done;  assign ifb.dm_load_done_i = dm_done;
  assign ifa.dm_data_l_i = dm_data;     assign ifb.dm_data_l_i = dm_data;

  urv_wb_stage #(.g_with_ecc(1)) dut_ecc (.clk_i(clk), .rst_n_i(rst_n), .bus(ifa.slave));
  urv_wb_stage #(.g_with_ecc(0)) dut_plain (.clk_i(clk), .rst_n_i(rst_n), .bus(ifb.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ECC built from an explicit 38-position Hamming codeword.
  function automatic logic [6:0] model_ecc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  e;
    int di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    e = '0;
    for (int k = 0; k < 6; k++)
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> k) & 1) != 0) e[k] = e[k] ^ cw[pos];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] fun, input logic [1:0] addr,
                                             input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (32'(addr) * 8)) & 32'hFF;
    h = (data >> (addr[1] ? 16 : 0)) & 32'hFFFF;
    case (fun)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return data;
    endcase
  endfunction

  // Monitor: every strobe from either instance must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && (ifa.rf_rd_store_o || ifb.rf_rd_store_o)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_store", 32'(ifa.rf_rd_store_o | ifb.rf_rd_store_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("store_ecc_inst", 32'(ifa.rf_rd_store_o), 32'd1);
        chk("store_plain_inst", 32'(ifb.rf_rd_store_o), 32'd1);
        chk("rd", 32'(ifa.rf_rd_o), 32'(e.rd));
        chk("value", ifa.rf_rd_value_o, e.value);
        chk("value_plain", ifb.rf_rd_value_o, e.value);
        chk("bypass_write", 32'(ifa.w_bypass_rd_write_o), 32'd1);
        chk("bypass_value", ifa.w_bypass_rd_value_o, e.value);
        chk("ecc", 32'(ifa.rf_rd_ecc_o), 32'(model_ecc(e.value)));
        chk("ecc_disabled", 32'(ifb.rf_rd_ecc_o), 32'd0);
      end
    end
  end

  task automatic idle(input int n, input bit stale);
    for (int i = 0; i < n; i++) begin
      x_valid = 1'b0;
      dm_done = stale ? 1'($urandom_range(0, 1)) : 1'b0;
      dm_data = $urandom;
      @(negedge clk);
    end
    dm_done = 1'b0;
  endtask

  // Called just after a negedge; returns just after a negedge with the stage idle.
  task automatic issue(input logic [4:0] rd, input logic wr, input logic [31:0] val,
                       input logic ld, input logic [2:0] fun, input logic [1:0] addr,
                       input logic [31:0] data, input int delay, input logic early_done);
    chk("ready_at_issue", 32'(ifa.x_ready_o), 32'd1);
    x_valid = 1'b1; x_rd = rd; x_rd_write = wr; x_rd_value = val;
    x_load = ld; x_fun = fun; x_addr = addr;
    dm_done = early_done; dm_data = ~data;
    if (!ld && wr && rd != 5'd0) exp_q.push_back('{rd, val});
    @(negedge clk);
    x_valid = 1'b0; dm_done = 1'b0; x_rd_value = $urandom; x_rd = 5'($urandom);
    if (ld) begin
      for (int i = 0; i < delay; i++) begin
        chk("ready_low_wait", 32'(ifa.x_ready_o), 32'd0);
        chk("pending_wait", 32'(ifb.w_load_pending_o), 32'd1);
        dm_data = $urandom;
        @(negedge clk);
      end
      chk("pending_done_cycle", 32'(ifa.w_load_pending_o), 32'd1);
      dm_done = 1'b1; dm_data = data;
      if (wr && rd != 5'd0) exp_q.push_back('{rd, model_load(fun, addr, data)});
      @(negedge clk);
      dm_done = 1'b0;
      chk("ready_after_load", 32'(ifa.x_ready_o), 32'd1);
      chk("pending_after_load", 32'(ifa.w_load_pending_o), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ifa.x_ready_o), 32'd1);
    chk("rst_store", 32'(ifa.rf_rd_store_o | ifb.rf_rd_store_o), 32'd0);
    chk("rst_value", ifa.rf_rd_value_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pending", 32'(ifa.w_load_pending_o), 32'd0);
    chk("post_rst_bypass", 32'(ifa.w_bypass_rd_write_o), 32'd0);

    // Directed cases
    issue(5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 32'd0, 0, 1'b0);
    idle(1, 1'b0);
    chk("alu_strobe_single", 32'(ifa.rf_rd_store_o), 32'd0);
    issue(5'd0, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 2'd0, 32'd0, 0, 1'b0);
    idle(1, 1'b0);
    chk("rd0_no_bypass", 32'(ifa.w_bypass_rd_write_o), 32'd0);
    issue(5'd7, 1'b1, 32'd0, 1'b1, 3'b000, 2'd3, 32'h80FF_0011, 3, 1'b0);
    issue(5'd8, 1'b1, 32'd0, 1'b1, 3'b100, 2'd3, 32'h80FF_0011, 3, 1'b0);
    issue(5'd9, 1'b1, 32'd0, 1'b1, 3'b101, 2'd2, 32'hBEEF_1234, 1, 1'b1);
    issue(5'd10, 1'b1, 32'd0, 1'b1, 3'b001, 2'd0, 32'h0000_8001, 0, 1'b0);
    issue(5'd11, 1'b1, 32'h0000_0000, 1'b0, 3'd0, 2'd0, 32'd0, 0, 1'b0);
    issue(5'd12, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0, 32'd0, 0, 1'b0);
    idle(2, 1'b1);

    // Reset during an outstanding load
    x_valid = 1'b1; x_rd = 5'd3; x_rd_write = 1'b1; x_load = 1'b1; x_fun = 3'b010;
    @(negedge clk);
    x_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pending", 32'(ifa.w_load_pending_o | ifb.w_load_pending_o), 32'd0);
    chk("midrst_store", 32'(ifa.rf_rd_store_o | ifb.rf_rd_store_o), 32'd0);
    chk("midrst_value", ifa.rf_rd_value_o, 32'd0);
    chk("midrst_rd", 32'(ifa.rf_rd_o), 32'd0);
    chk("midrst_ecc", 32'(ifa.rf_rd_ecc_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dm_done = 1'b1; dm_data = 32'hCAFE_F00D;
    @(negedge clk);
    dm_done = 1'b0;
    chk("late_done_ready", 32'(ifa.x_ready_o), 32'd1);
    @(negedge clk);
    chk("late_done_no_store", 32'(ifa.rf_rd_store_o | ifb.rf_rd_store_o), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [2:0] fun;
      fun = 3'($urandom);
      issue(5'($urandom), ($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
            fun, 2'($urandom), $urandom, $urandom_range(0, 4), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), 1'b1);
    end

    idle(4, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
